// File: rtl/fewcore_rf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : fewcore_rf_pkg                                                |
// | Purpose  : Shared defaults, address-width helper and word/address types  |
// |            for the fewcore register file.                                |
// | Revision : 1.0 - initial parametrised release                            |
// +--------------------------------------------------------------------------+
package fewcore_rf_pkg;

   localparam int unsigned c_data_w_def = 32;
   localparam int unsigned c_depth_def  = 16;

   // Never returns 0 so a degenerate depth still yields a legal port width.
   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   typedef logic [c_data_w_def-1:0]         rf_word_t;
   typedef logic [$clog2(c_depth_def)-1:0]  rf_addr_t;

endpackage
`default_nettype wire

// File: rtl/reg_bank_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_bank_scoreboard                                           |
// | Purpose  : Per-register busy bits: reserve on issue, release on          |
// |            writeback, plus a registered busy population count.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module reg_bank_scoreboard
   import fewcore_rf_pkg::*;
#(
   parameter int unsigned  DEPTH    = c_depth_def,
   parameter bit           ZERO_REG = 1'b1,
   localparam int unsigned AW       = addr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_rsv_en,
   input  logic [AW-1:0]    i_rsv_addr,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   output logic             o_rsv_ready,
   output logic [DEPTH-1:0] o_busy,
   output logic [AW:0]      o_busy_cnt
);

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_set_mask;
   logic [DEPTH-1:0] w_clr_mask;
   logic [DEPTH-1:0] w_busy_nxt;
   logic [AW:0]      r_busy_cnt;
   logic [AW:0]      w_busy_cnt_nxt;
   logic             w_rsv_zero;

   // Ready looks only at registered state, so a same-cycle writeback never
   // shortens the path from wr_* to the issue stage.
   assign o_rsv_ready = ~r_busy[i_rsv_addr];
   assign w_rsv_zero  = ZERO_REG && (i_rsv_addr == '0);

   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (i_rsv_en && o_rsv_ready && !w_rsv_zero) begin
         w_set_mask[i_rsv_addr] = 1'b1;
      end
      if (i_wr_en) begin
         w_clr_mask[i_wr_addr] = 1'b1;
      end
      // Set after clear: a new producer issued in the writeback cycle wins.
      w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
   end

   always_comb begin
      w_busy_cnt_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_busy_cnt_nxt = w_busy_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= w_busy_cnt_nxt;
      end
   end

   assign o_busy     = r_busy;
   assign o_busy_cnt = r_busy_cnt;

endmodule
`default_nettype wire

// File: rtl/reg_bank_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_bank_sb                                                   |
// | Purpose  : Parametrised 2R/1W register bank with busy scoreboard.        |
// |            Define REG_BANK_BYPASS_EN for same-cycle write-to-read bypass.|
// | Revision : 1.0 - initial parametrised release                            |
// +--------------------------------------------------------------------------+
module reg_bank_sb
   import fewcore_rf_pkg::*;
#(
   parameter int unsigned  DATA_W   = c_data_w_def,
   parameter int unsigned  DEPTH    = c_depth_def,
   parameter bit           ZERO_REG = 1'b1,
   localparam int unsigned AW       = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AW-1:0]     rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   output logic              rd_busy_a,
   input  logic [AW-1:0]     rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_busy_b,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_addr,
   output logic              rsv_ready,
   output logic [AW:0]       busy_cnt
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  w_busy;
   logic              w_wr_ok;
   logic              w_zero_a;
   logic              w_zero_b;
   logic [DATA_W-1:0] w_stored_a;
   logic [DATA_W-1:0] w_stored_b;

   // Writes to the hardwired zero register are dropped here, so its
   // storage flop holds reset value forever and folds away in synthesis.
   assign w_wr_ok = wr_en && !(ZERO_REG && (wr_addr == '0));

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_mem[gi] <= '0;
            end else if (w_wr_ok && (wr_addr == AW'(gi))) begin
               r_mem[gi] <= wr_data;
            end
         end
      end
   endgenerate

   reg_bank_scoreboard #(
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rsv_en    (rsv_en),
      .i_rsv_addr  (rsv_addr),
      .i_wr_en     (w_wr_ok),
      .i_wr_addr   (wr_addr),
      .o_rsv_ready (rsv_ready),
      .o_busy      (w_busy),
      .o_busy_cnt  (busy_cnt)
   );

   assign w_zero_a   = ZERO_REG && (rd_addr_a == '0);
   assign w_zero_b   = ZERO_REG && (rd_addr_b == '0);
   assign w_stored_a = w_zero_a ? '0 : r_mem[rd_addr_a];
   assign w_stored_b = w_zero_b ? '0 : r_mem[rd_addr_b];

`ifdef REG_BANK_BYPASS_EN
   logic w_byp_a;
   logic w_byp_b;

   // w_wr_ok already excludes the zero register, so it is never bypassed.
   assign w_byp_a   = w_wr_ok && (wr_addr == rd_addr_a);
   assign w_byp_b   = w_wr_ok && (wr_addr == rd_addr_b);
   assign rd_data_a = w_byp_a ? wr_data : w_stored_a;
   assign rd_data_b = w_byp_b ? wr_data : w_stored_b;
   assign rd_busy_a = !w_byp_a && !w_zero_a && w_busy[rd_addr_a];
   assign rd_busy_b = !w_byp_b && !w_zero_b && w_busy[rd_addr_b];
`else
   assign rd_data_a = w_stored_a;
   assign rd_data_b = w_stored_b;
   assign rd_busy_a = !w_zero_a && w_busy[rd_addr_a];
   assign rd_busy_b = !w_zero_b && w_busy[rd_addr_b];
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_reg_bank_sb                                                |
// | Purpose  : Directed, scoreboard-checked bench for reg_bank_sb.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_reg_bank_sb;
   import fewcore_rf_pkg::*;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned AW     = 4;

`ifdef REG_BANK_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam int S_DA = 0;
   localparam int S_DB = 1;
   localparam int S_BA = 2;
   localparam int S_BB = 3;
   localparam int S_CNT = 4;
   localparam int S_RDY = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [AW-1:0]     rd_addr_a = '0;
   logic [DATA_W-1:0] rd_data_a;
   logic              rd_busy_a;
   logic [AW-1:0]     rd_addr_b = '0;
   logic [DATA_W-1:0] rd_data_b;
   logic              rd_busy_b;
   logic              wr_en = 1'b0;
   logic [AW-1:0]     wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              rsv_en = 1'b0;
   logic [AW-1:0]     rsv_addr = '0;
   logic              rsv_ready;
   logic [AW:0]       busy_cnt;

   reg_bank_sb #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (rd_addr_a),
      .rd_data_a (rd_data_a),
      .rd_busy_a (rd_busy_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_b (rd_data_b),
      .rd_busy_b (rd_busy_b),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .rsv_ready (rsv_ready),
      .busy_cnt  (busy_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          sig;
      logic [31:0] exp;
      string       name;
   } chk_t;

   chk_t exp_q[$];
   int   cyc_cnt = 0;
   int   total = 0;
   int   bad = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic logic [31:0] sample(input int sig);
      case (sig)
         S_DA:    return rd_data_a;
         S_DB:    return rd_data_b;
         S_BA:    return {31'b0, rd_busy_a};
         S_BB:    return {31'b0, rd_busy_b};
         S_CNT:   return {27'b0, busy_cnt};
         S_RDY:   return {31'b0, rsv_ready};
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Monitor: on each falling edge, retire every expectation due this cycle.
   always @(negedge clk) begin
      int i;
      logic [31:0] act;
      i = 0;
      while (i < exp_q.size()) begin
         if (exp_q[i].cyc == cyc_cnt) begin
            act = sample(exp_q[i].sig);
            total++;
            if (act !== exp_q[i].exp) begin
               bad++;
               $display("FAIL %s: got %h expected %h (cycle %0d)",
                        exp_q[i].name, act, exp_q[i].exp, cyc_cnt);
            end
            exp_q.delete(i);
         end else if (exp_q[i].cyc < cyc_cnt) begin
            total++;
            bad++;
            $display("FAIL %s: never sampled, expected %h", exp_q[i].name, exp_q[i].exp);
            exp_q.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      wr_en  = 1'b0;
      rsv_en = 1'b0;
   endtask

   task automatic chk(input int sig, input logic [31:0] exp, input string name, input int dly = 0);
      chk_t c;
      c.cyc  = cyc_cnt + dly;
      c.sig  = sig;
      c.exp  = exp;
      c.name = name;
      exp_q.push_back(c);
   endtask

   task automatic do_wr(input logic [AW-1:0] a, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
   endtask

   task automatic do_rsv(input logic [AW-1:0] a);
      rsv_en   = 1'b1;
      rsv_addr = a;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, expected test end");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Post-reset sweep of all addresses on both ports
      for (int a = 0; a < int'(DEPTH); a++) begin
         step();
         rd_addr_a = AW'(a);
         rd_addr_b = AW'(int'(DEPTH) - 1 - a);
         rsv_addr  = AW'(a);
         chk(S_DA, 32'h0, "reset_data_a");
         chk(S_DB, 32'h0, "reset_data_b");
         chk(S_BA, 32'h0, "reset_busy_a");
         chk(S_BB, 32'h0, "reset_busy_b");
         chk(S_CNT, 32'h0, "reset_busy_cnt");
         chk(S_RDY, 32'h1, "reset_rsv_ready");
      end

      // Plain write, then zero-register write
      step();
      do_wr(4'd5, 32'hDEAD_BEEF);
      rd_addr_a = 4'd5;
      chk(S_DA, BYP ? 32'hDEAD_BEEF : 32'h0, "wr_r5_same_cycle");
      step();
      rd_addr_a = 4'd5;
      rd_addr_b = 4'd5;
      chk(S_DA, 32'hDEAD_BEEF, "r5_port_a");
      chk(S_DB, 32'hDEAD_BEEF, "r5_port_b");
      step();
      do_wr(4'd0, 32'h1234);
      rd_addr_a = 4'd0;
      chk(S_DA, 32'h0, "r0_write_no_bypass");
      step();
      rd_addr_a = 4'd0;
      rd_addr_b = 4'd0;
      chk(S_DA, 32'h0, "r0_reads_zero_a");
      chk(S_DB, 32'h0, "r0_reads_zero_b");
      chk(S_BA, 32'h0, "r0_not_busy");

      // Reserve, blocked re-reserve, release by writeback
      step();
      do_rsv(4'd3);
      chk(S_RDY, 32'h1, "rsv_r3_ready");
      chk(S_CNT, 32'h0, "rsv_r3_cnt_before");
      step();
      do_rsv(4'd3);
      rd_addr_a = 4'd3;
      chk(S_RDY, 32'h0, "rsv_r3_blocked");
      chk(S_CNT, 32'h1, "rsv_r3_cnt");
      chk(S_BA, 32'h1, "rsv_r3_busy");
      step();
      do_wr(4'd3, 32'h33);
      rd_addr_a = 4'd3;
      chk(S_CNT, 32'h1, "r3_cnt_held");
      chk(S_BA, BYP ? 32'h0 : 32'h1, "r3_busy_at_wb");
      step();
      rd_addr_a = 4'd3;
      chk(S_CNT, 32'h0, "r3_released_cnt");
      chk(S_BA, 32'h0, "r3_released_busy");
      chk(S_DA, 32'h33, "r3_data");

      // Zero register can never become busy
      step();
      do_rsv(4'd0);
      chk(S_RDY, 32'h1, "rsv_r0_ready");
      step();
      rd_addr_a = 4'd0;
      chk(S_CNT, 32'h0, "rsv_r0_cnt");
      chk(S_BA, 32'h0, "rsv_r0_busy");

      // Same-cycle write and reservation to an idle register
      step();
      do_wr(4'd7, 32'h55);
      do_rsv(4'd7);
      chk(S_RDY, 32'h1, "r7_rsv_ready");
      step();
      rd_addr_a = 4'd7;
      chk(S_DA, 32'h55, "r7_data");
      chk(S_BA, 32'h1, "r7_busy");
      chk(S_CNT, 32'h1, "r7_cnt");

      // Writeback releases while a reservation is blocked; retry succeeds
      step();
      do_wr(4'd7, 32'h66);
      do_rsv(4'd7);
      chk(S_RDY, 32'h0, "r7_blocked_despite_wr");
      step();
      do_rsv(4'd7);
      rd_addr_a = 4'd7;
      chk(S_RDY, 32'h1, "r7_retry_ready");
      chk(S_CNT, 32'h0, "r7_cleared_cnt");
      chk(S_DA, 32'h66, "r7_data_66");
      step();
      do_wr(4'd7, 32'h77);
      rd_addr_a = 4'd7;
      chk(S_CNT, 32'h1, "r7_reserved_again");
      chk(S_BA, BYP ? 32'h0 : 32'h1, "r7_busy_at_wb2");
      step();
      chk(S_CNT, 32'h0, "r7_final_release");

      // Write while reading the same register
      step();
      do_wr(4'd9, 32'hA5);
      rd_addr_a = 4'd9;
      rd_addr_b = 4'd5;
      chk(S_DA, BYP ? 32'hA5 : 32'h0, "r9_same_cycle");
      chk(S_BA, 32'h0, "r9_busy");
      chk(S_DB, 32'hDEAD_BEEF, "r5_on_b_during_wr");
      step();
      rd_addr_a = 4'd9;
      chk(S_DA, 32'hA5, "r9_next_cycle");

      // Reservations then asynchronous reset mid-cycle
      step();
      do_rsv(4'd1);
      step();
      do_rsv(4'd2);
      step();
      do_rsv(4'd4);
      step();
      chk(S_CNT, 32'h3, "three_reserved");
      step();
      rst_n     = 1'b0;
      rd_addr_a = 4'd5;
      rd_addr_b = 4'd7;
      chk(S_CNT, 32'h0, "async_rst_cnt");
      chk(S_DA, 32'h0, "async_rst_r5");
      chk(S_DB, 32'h0, "async_rst_r7");
      step();
      rd_addr_a = 4'd1;
      rd_addr_b = 4'd9;
      rsv_addr  = 4'd4;
      chk(S_BA, 32'h0, "rst_r1_busy");
      chk(S_DB, 32'h0, "rst_r9_data");
      chk(S_RDY, 32'h1, "rst_r4_ready");
      step();
      rst_n     = 1'b1;
      rd_addr_a = 4'd3;
      chk(S_CNT, 32'h0, "post_rst_cnt");
      chk(S_DA, 32'h0, "post_rst_r3");

      for (int k = 0; k < 5 && exp_q.size() > 0; k++) step();
      if (exp_q.size() > 0) begin
         $display("FAIL drain: %0d checks pending, expected 0", exp_q.size());
         total += exp_q.size();
         bad   += exp_q.size();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
